wb_slave_regfile: RTL and testbench

//   Wishbone B4 classic slave holding NUM_REGS read/write registers, each DATA_WIDTH wide.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_regfile_decode.sv | 28 ++
 rtl/wb_slave_regfile.sv | 120 ++++++++++++
 tb/tb_wb_slave_regfile.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: transfer FSM states, lane merge helper,
// and index-width helper used by the register file slave and its decoder.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PROCESS,
    WAIT_FOR_PHASE_END
  } wb_slave_state_t;

  // Bit b of the result takes new_data[b] when the lane holding bit b is selected.
  function automatic logic [63:0] wb_lane_merge(input logic [63:0] old_data,
                                                input logic [63:0] new_data,
                                                input logic [63:0] sel,
                                                input int unsigned granule);
    logic [63:0] result;
    result = old_data;
    for (int unsigned b = 0; b < 64; b++) begin
      if (sel[b / granule]) result[b] = new_data[b];
    end
    return result;
  endfunction

  function automatic int unsigned wb_idx_width(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/wb_regfile_decode.sv
// Combinational address decode for the register file slave: byte address to
// register index plus an in-window flag (addresses below the base never wrap in).
module wb_regfile_decode
  import wb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  localparam int unsigned          IDX_WIDTH  = wb_idx_width(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] adr,
  output logic [IDX_WIDTH-1:0]  idx,
  output logic                  in_range
);

  localparam int unsigned           SHIFT     = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] REG_COUNT = ADDR_WIDTH'(NUM_REGS);

  logic [ADDR_WIDTH-1:0] word;

  always_comb begin
    word     = (adr - BASE_ADDR) >> SHIFT;
    idx      = word[IDX_WIDTH-1:0];
    in_range = (adr >= BASE_ADDR) && (word < REG_COUNT);
  end

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone B4 classic slave with NUM_REGS lane-writable registers and a flat q_o view.
// Define WB_REGFILE_ERR_EN to terminate out-of-range accesses with err_o instead of ack_o.
module wb_slave_regfile
  import wb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           GRANULE    = 8,
  parameter int unsigned           NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  localparam int unsigned          SEL_WIDTH  = DATA_WIDTH / GRANULE
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ADDR_WIDTH-1:0]          adr_i,
  input  logic [DATA_WIDTH-1:0]          dat_i,
  output logic [DATA_WIDTH-1:0]          dat_o,
  input  logic [SEL_WIDTH-1:0]           sel_i,
  input  logic                           we_i,
  input  logic                           stb_i,
  input  logic                           cyc_i,
  output logic                           ack_o,
  output logic                           err_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] q_o
);

  localparam int unsigned IDX_WIDTH = wb_idx_width(NUM_REGS);

  wb_slave_state_t       state, state_next;
  logic                  ack_flag;
  logic [IDX_WIDTH-1:0]  idx;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] cur_reg;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  wb_regfile_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_decode (
    .adr      (adr_i),
    .idx      (idx),
    .in_range (in_range)
  );

  // Out-of-range source reads as zero so a non-error read clears its selected lanes.
  always_comb begin
    cur_reg = in_range ? regs[idx] : '0;
    wr_data = DATA_WIDTH'(wb_lane_merge(64'(cur_reg), 64'(dat_i), 64'(sel_i), GRANULE));
    rd_data = DATA_WIDTH'(wb_lane_merge(64'(dat_o), 64'(cur_reg), 64'(sel_i), GRANULE));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:               if (cyc_i && stb_i) state_next = PROCESS;
      PROCESS:            state_next = WAIT_FOR_PHASE_END;
      WAIT_FOR_PHASE_END: if (!stb_i || !cyc_i) state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

`ifdef WB_REGFILE_ERR_EN
  logic err_flag;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_flag <= 1'b0;
    end else if (state == PROCESS) begin
      err_flag <= !in_range;
    end else if (state == WAIT_FOR_PHASE_END && (!stb_i || !cyc_i)) begin
      err_flag <= 1'b0;
    end
  end

  assign err_o = stb_i & cyc_i & err_flag;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      ack_flag <= 1'b0;
      dat_o    <= '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      state <= state_next;
      case (state)
        PROCESS: begin
          if (in_range) begin
            ack_flag <= 1'b1;
            if (we_i) regs[idx] <= wr_data;
            else      dat_o     <= rd_data;
          end else begin
`ifndef WB_REGFILE_ERR_EN
            ack_flag <= 1'b1;
            if (!we_i) dat_o <= rd_data;
`endif
          end
        end
        WAIT_FOR_PHASE_END: begin
          if (!stb_i || !cyc_i) ack_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ack_o = stb_i & cyc_i & ack_flag;

  always_comb begin
    q_o = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) q_o[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
  end

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Self-checking bench for wb_slave_regfile (BASE_ADDR 'h100); expectations follow
// WB_REGFILE_ERR_EN when it is defined for the build.
module tb_wb_slave_regfile;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 8;
  localparam logic [AW-1:0] BASE = 16'h0100;
`ifdef WB_REGFILE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdat;
  logic [DW-1:0] rdat;
  logic [3:0]    sel;
  logic          we, stb, cyc;
  logic          ack, err;
  logic [NR*DW-1:0] q;

  always #5 clk = ~clk;

  wb_slave_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .GRANULE    (8),
    .NUM_REGS   (NR),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .adr_i (adr),
    .dat_i (wdat),
    .dat_o (rdat),
    .sel_i (sel),
    .we_i  (we),
    .stb_i (stb),
    .cyc_i (cyc),
    .ack_o (ack),
    .err_o (err),
    .q_o   (q)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] m_dat;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [3:0]    sel;
    logic          exp_err;
    logic [DW-1:0] exp_rd;
  } vec_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_q();
    logic [NR*DW-1:0] r;
    for (int k = 0; k < NR; k++) r[k*DW +: DW] = m_regs[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NR; k++) m_regs[k] = '0;
    m_dat = '0;
  endtask

  // Reference: byte masks, word index = (adr - base) / 4.
  task automatic model_xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, output logic e_ack, output logic e_err);
    logic [AW-1:0] off;
    logic [DW-1:0] mask;
    int            ix;
    bit            inr;
    off  = a - BASE;
    ix   = int'(off) / 4;
    inr  = (a >= BASE) && (ix < NR);
    mask = '0;
    for (int i = 0; i < 4; i++) if (s[i]) mask[8*i +: 8] = 8'hFF;
    e_ack = 1'b1;
    e_err = 1'b0;
    if (inr) begin
      if (w) m_regs[ix] = (m_regs[ix] & ~mask) | (d & mask);
      else   m_dat      = (m_dat & ~mask) | (m_regs[ix] & mask);
    end else if (ERR_EN) begin
      e_ack = 1'b0;
      e_err = 1'b1;
    end else if (!w) begin
      m_dat = m_dat & ~mask;
    end
  endtask

  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [3:0] s, output logic g_ack, output logic g_err,
                      output logic [DW-1:0] g_dat, output int unsigned lat);
    @(negedge clk);
    we = w; adr = a; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (ack || err) break;
    end
    g_ack = ack;
    g_err = err;
    g_dat = rdat;
    cyc = 1'b0;
    stb = 1'b0;
  endtask

  vec_t          tbl [12];
  logic          g_ack, g_err, e_ack, e_err;
  logic [DW-1:0] g_dat;
  int unsigned   lat;

  initial begin
    rst = 1'b1; adr = '0; wdat = '0; sel = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ack", ack, 0);
    check("reset_err", err, 0);
    check("reset_dat", rdat, 0);
    check("reset_q", q, 0);
    rst = 1'b0;

    for (int k = 0; k < NR; k++) begin
      xfer(1'b0, BASE + AW'(4 * k), '0, 4'hF, g_ack, g_err, g_dat, lat);
      check("init_read_ack", g_ack, 1);
      check("init_read_dat", g_dat, 0);
    end
    check("init_q", q, 0);

    tbl[0]  = '{1'b1, 16'h0108, 32'hDEADBEEF, 4'b1111, 1'b0,   32'h00000000};
    tbl[1]  = '{1'b0, 16'h0108, 32'h00000000, 4'b1111, 1'b0,   32'hDEADBEEF};
    tbl[2]  = '{1'b1, 16'h0108, 32'h11223344, 4'b0101, 1'b0,   32'hDEADBEEF};
    tbl[3]  = '{1'b0, 16'h010A, 32'h00000000, 4'b1111, 1'b0,   32'hDE22BE44};
    tbl[4]  = '{1'b1, 16'h0120, 32'hCAFEF00D, 4'b1111, ERR_EN, 32'hDE22BE44};
    tbl[5]  = '{1'b1, 16'h00FC, 32'h12345678, 4'b1111, ERR_EN, 32'hDE22BE44};
    tbl[6]  = '{1'b0, 16'h0120, 32'h00000000, 4'b1111, ERR_EN, ERR_EN ? 32'hDE22BE44 : 32'h0};
    tbl[7]  = '{1'b1, 16'h011C, 32'h55555555, 4'b0000, 1'b0,   ERR_EN ? 32'hDE22BE44 : 32'h0};
    tbl[8]  = '{1'b0, 16'h011C, 32'h00000000, 4'b0011, 1'b0,   ERR_EN ? 32'hDE220000 : 32'h0};
    tbl[9]  = '{1'b1, 16'h0104, 32'hA5A5A5A5, 4'b1100, 1'b0,   ERR_EN ? 32'hDE220000 : 32'h0};
    tbl[10] = '{1'b0, 16'h0104, 32'h00000000, 4'b1000, 1'b0,   ERR_EN ? 32'hA5220000 : 32'hA5000000};
    tbl[11] = '{1'b0, 16'h00FF, 32'h00000000, 4'b1111, ERR_EN, ERR_EN ? 32'hA5220000 : 32'h0};

    for (int i = 0; i < 12; i++) begin
      model_xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, e_ack, e_err);
      xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, g_ack, g_err, g_dat, lat);
      check("tbl_latency", lat, 2);
      check("tbl_ack", g_ack, !tbl[i].exp_err);
      check("tbl_err", g_err, tbl[i].exp_err);
      check("tbl_dat", g_dat, tbl[i].exp_rd);
      check("tbl_q", q, model_q());
    end
    check("tbl_reg2", q[95:64], 32'hDE22BE44);

    for (int i = 0; i < 150; i++) begin
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [3:0]    s;
      w = 1'($urandom_range(0, 1));
      a = 16'h00F0 + AW'($urandom_range(0, 63));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      model_xfer(w, a, d, s, e_ack, e_err);
      xfer(w, a, d, s, g_ack, g_err, g_dat, lat);
      check("rnd_latency", lat, 2);
      check("rnd_ack", g_ack, e_ack);
      check("rnd_err", g_err, e_err);
      check("rnd_dat", g_dat, m_dat);
      check("rnd_q", q, model_q());
    end

    // Reset during the PROCESS cycle of a write to reg4.
    @(negedge clk);
    we = 1'b1; adr = 16'h0110; wdat = 32'hFFFFFFFF; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_ack", ack, 0);
    check("rstmid_err", err, 0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rstmid_ack_after", ack, 0);
    end
    check("rstmid_q", q, 0);
    check("rstmid_dat", rdat, 0);

    // Hold stb for five cycles: ack from the third cycle on, dropping with stb.
    @(posedge clk); #1;
    we = 1'b0; adr = 16'h0100; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("hold_ack", ack, (c >= 3) ? 1 : 0);
      check("hold_err", err, 0);
      @(posedge clk); #1;
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("hold_ack_drop", ack, 0);

    // cyc dropped during PROCESS: the write still lands, the FSM returns to idle.
    @(negedge clk);
    we = 1'b1; adr = 16'h0114; wdat = 32'h13572468; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    model_xfer(1'b1, 16'h0114, 32'h13572468, 4'hF, e_ack, e_err);
    @(negedge clk);
    check("cycdrop_q", q, model_q());
    check("cycdrop_ack", ack, 0);
    model_xfer(1'b0, 16'h0114, '0, 4'hF, e_ack, e_err);
    xfer(1'b0, 16'h0114, '0, 4'hF, g_ack, g_err, g_dat, lat);
    check("cycdrop_next_latency", lat, 2);
    check("cycdrop_next_ack", g_ack, 1);
    check("cycdrop_next_dat", g_dat, m_dat);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
